// File: rtl/timer_pkg.sv
// Shared types, BCD digit limits and the preset validity check for the MM:SS timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // A preset is usable only if it is proper BCD and within the minute limit.
    function automatic logic bcd_valid(input logic [15:0] value, input int max_min);
        logic digits_ok;
        int   minutes;
        digits_ok = (value[15:12] <= DIGIT_MAX) && (value[11:8] <= DIGIT_MAX) &&
                    (value[7:4] <= SEC_TENS_MAX) && (value[3:0] <= DIGIT_MAX);
        minutes   = int'(value[15:12]) * 10 + int'(value[11:8]);
        return digits_ok && (minutes <= max_min);
    endfunction

endpackage

// File: rtl/mmss_bcd_counter.sv
// Four-digit MM:SS BCD count register with clear/load/increment/decrement.
module mmss_bcd_counter
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] count,
    output logic        at_zero,
    output logic        at_max
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    logic [15:0] count_q;
    logic [15:0] count_d;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] < DIGIT_MAX) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] < SEC_TENS_MAX) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] < DIGIT_MAX) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = DIGIT_MAX;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = SEC_TENS_MAX;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = DIGIT_MAX;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign at_zero = (count_q == 16'h0000);
    assign at_max  = (count_q[15:12] == MAX_TENS) && (count_q[11:8] == MAX_ONES) &&
                     (count_q[7:0] == 8'h59);
    assign count   = count_q;

    // Next count; the limits are saturating so the register never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 16'h0000;
        end else if (load) begin
            count_d = load_value;
        end else if (inc && !at_max) begin
            count_d = bcd_inc(count_q);
        end else if (dec && !at_zero) begin
            count_d = bcd_dec(count_q);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/updown_timer_ctrl.sv
// MM:SS up/down timer controller: run/pause FSM, seconds prescaler, preset load.
// Optional input conditioning is enabled with `define BUTTON_DEBOUNCE_EN.
module updown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 12000000,
    parameter int MAX_MIN  = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_dir,
    input  logic        btn_clear,
    input  logic        load_en,
    input  logic [15:0] load_value,
    output logic [15:0] four_hex_out,
    output logic        running,
    output logic        dir_up,
    output logic        expired,
    output logic        load_err,
    output logic        sec_tick
);

    localparam int            PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);

    logic start_p, dir_p, clear_p;

`ifdef BUTTON_DEBOUNCE_EN
    localparam int DEBOUNCE_CYC = (TICK_DIV / 1000 < 2) ? 2 : TICK_DIV / 1000;
    localparam int DW           = $clog2(DEBOUNCE_CYC + 1);

    logic [2:0]    sync1_q, sync2_q, level_q, pulse_q;
    logic [DW-1:0] db_cnt_q [3];

    // Two-flop sync, then accept a new level only after it has held steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            level_q <= 3'b000;
            pulse_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {btn_clear, btn_dir, btn_start};
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                    pulse_q[i]  <= 1'b0;
                end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync2_q[i];
                    pulse_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                    pulse_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign start_p = pulse_q[0];
    assign dir_p   = pulse_q[1];
    assign clear_p = pulse_q[2];
`else
    assign start_p = btn_start;
    assign dir_p   = btn_dir;
    assign clear_p = btn_clear;
`endif

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          tick_q, tick_d;
    logic          load_err_q, load_err_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          load_ok;
    logic          cnt_clear, cnt_load, cnt_inc, cnt_dec;
    logic [15:0]   cnt_value;
    logic          cnt_at_zero, cnt_at_max;

    mmss_bcd_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (load_value),
        .inc        (cnt_inc),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .at_zero    (cnt_at_zero),
        .at_max     (cnt_at_max)
    );

    // State, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= PRESC_RELOAD;
            dir_q      <= 1'b1;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
        end
    end

    // Next state: clear > load > start > tick; direction toggles independently.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        dir_d      = dir_p ? ~dir_q : dir_q;
        load_ok    = bcd_valid(load_value, MAX_MIN) && (state_q != RUN);

        if (clear_p) begin
            state_d   = IDLE;
            presc_d   = PRESC_RELOAD;
            cnt_clear = 1'b1;
        end else if (load_en && load_ok) begin
            cnt_load = 1'b1;
            state_d  = (state_q == EXPIRED) ? IDLE : state_q;
        end else begin
            load_err_d = load_en;
            if (start_p) begin
                case (state_q)
                    IDLE, PAUSE: begin
                        // Counting down from zero has nothing to do but expire.
                        if (!dir_q && cnt_at_zero) begin
                            state_d = EXPIRED;
                        end else begin
                            state_d = RUN;
                            presc_d = (state_q == IDLE) ? PRESC_RELOAD : presc_q;
                        end
                    end
                    RUN:     state_d = PAUSE;
                    EXPIRED: state_d = EXPIRED;
                    default: state_d = IDLE;
                endcase
            end else if (state_q == RUN) begin
                if (presc_q == '0) begin
                    presc_d = PRESC_RELOAD;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q - PW'(1);
                end
                if (tick_q) begin
                    if (dir_q) begin
                        if (cnt_at_max) begin
                            state_d = EXPIRED;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        if (cnt_at_zero) begin
                            state_d = EXPIRED;
                        end else begin
                            cnt_dec = 1'b1;
                            state_d = (cnt_value == 16'h0001) ? EXPIRED : RUN;
                        end
                    end
                end else begin
                    state_d = RUN;
                end
            end else begin
                state_d = state_q;
            end
        end
    end

    // Status flags follow the state being entered so they register with it.
    always_comb begin
        running_d = 1'b0;
        expired_d = 1'b0;
        case (state_d)
            RUN:     running_d = 1'b1;
            EXPIRED: expired_d = 1'b1;
            default: begin
                running_d = 1'b0;
                expired_d = 1'b0;
            end
        endcase
    end

    assign four_hex_out = cnt_value;
    assign running      = running_q;
    assign dir_up       = dir_q;
    assign expired      = expired_q;
    assign load_err     = load_err_q;
    assign sec_tick     = tick_q;

endmodule

// File: tb/tb_updown_timer_ctrl.sv
// Directed bench for updown_timer_ctrl with a fast prescaler; expectations queued then checked.
module tb_updown_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start, btn_dir, btn_clear, load_en;
    logic [15:0] load_value;

    logic [15:0] a_cnt, b_cnt;
    logic        a_run, a_dir, a_exp, a_lerr, a_tick;
    logic        b_run, b_dir, b_exp, b_lerr, b_tick;

    int checks = 0;
    int errors = 0;
    int n;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    updown_timer_ctrl #(.TICK_DIV(4), .MAX_MIN(99)) u_a (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_dir(btn_dir),
        .btn_clear(btn_clear), .load_en(load_en), .load_value(load_value),
        .four_hex_out(a_cnt), .running(a_run), .dir_up(a_dir), .expired(a_exp),
        .load_err(a_lerr), .sec_tick(a_tick)
    );

    updown_timer_ctrl #(.TICK_DIV(4), .MAX_MIN(1)) u_b (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_dir(btn_dir),
        .btn_clear(btn_clear), .load_en(load_en), .load_value(load_value),
        .four_hex_out(b_cnt), .running(b_run), .dir_up(b_dir), .expired(b_exp),
        .load_err(b_lerr), .sec_tick(b_tick)
    );

    task automatic expect_push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic pulse(input logic s, input logic d, input logic c, input logic l,
                         input logic [15:0] v);
        btn_start  = s;
        btn_dir    = d;
        btn_clear  = c;
        load_en    = l;
        load_value = v;
        @(negedge clk);
        btn_start  = 1'b0;
        btn_dir    = 1'b0;
        btn_clear  = 1'b0;
        load_en    = 1'b0;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (a_tick !== 1'b1 && cyc < 40);
    endtask

    initial begin
        reset = 1'b1; btn_start = 1'b0; btn_dir = 1'b0; btn_clear = 1'b0;
        load_en = 1'b0; load_value = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset values
        expect_push("rst_cnt", 32'h0); expect_push("rst_dir", 32'h1);
        expect_push("rst_run", 32'h0); expect_push("rst_exp", 32'h0);
        expect_push("rst_lerr", 32'h0); expect_push("rst_tick", 32'h0);
        check_pop(32'(a_cnt)); check_pop(32'(a_dir)); check_pop(32'(a_run));
        check_pop(32'(a_exp)); check_pop(32'(a_lerr)); check_pop(32'(a_tick));

        // count up from zero
        expect_push("start_run", 32'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_run));
        for (int k = 0; k < 3; k++) begin
            expect_push("tick_gap", 32'd4);
            expect_push("up_cnt", 32'(k));
            wait_tick(n);
            check_pop(32'(n));
            check_pop(32'(a_cnt));
        end
        for (int k = 0; k < 58; k++) begin
            expect_push("tick_gap_long", 32'd4);
            wait_tick(n);
            check_pop(32'(n));
        end
        expect_push("cnt_60s", 32'h0100);
        check_pop(32'(a_cnt));

        // clear wins over start
        expect_push("clr_cnt", 32'h0); expect_push("clr_run", 32'h0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_pop(32'(a_cnt)); check_pop(32'(a_run));

        // count down to expiry
        expect_push("ld2_cnt", 32'h0002); expect_push("ld2_lerr", 32'h0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0002);
        check_pop(32'(a_cnt)); check_pop(32'(a_lerr));
        expect_push("dir_down", 32'h0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_dir));
        expect_push("dn_run", 32'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_run));
        expect_push("dn_gap1", 32'd4); expect_push("dn_cnt_pre", 32'h0002);
        wait_tick(n);
        check_pop(32'(n)); check_pop(32'(a_cnt));
        @(negedge clk);
        expect_push("dn_cnt1", 32'h0001); expect_push("dn_exp1", 32'h0);
        check_pop(32'(a_cnt)); check_pop(32'(a_exp));
        expect_push("dn_gap2", 32'd3);
        wait_tick(n);
        check_pop(32'(n));
        @(negedge clk);
        expect_push("dn_cnt0", 32'h0000); expect_push("dn_exp", 32'h1);
        expect_push("dn_run_off", 32'h0);
        check_pop(32'(a_cnt)); check_pop(32'(a_exp)); check_pop(32'(a_run));
        repeat (10) @(negedge clk);
        expect_push("exp_hold_cnt", 32'h0); expect_push("exp_hold_tick", 32'h0);
        check_pop(32'(a_cnt)); check_pop(32'(a_tick));
        expect_push("exp_start_exp", 32'h1); expect_push("exp_start_run", 32'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_exp)); check_pop(32'(a_run));

        // down start at zero expires immediately
        expect_push("clr_exp", 32'h0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_pop(32'(a_exp));
        expect_push("zero_start_exp", 32'h1); expect_push("zero_start_run", 32'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_exp)); check_pop(32'(a_run));

        // load rejection
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        expect_push("bad_bcd_lerr", 32'h1); expect_push("bad_bcd_cnt", 32'h0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0075);
        check_pop(32'(a_lerr)); check_pop(32'(a_cnt));
        expect_push("lerr_one_cycle", 32'h0);
        @(negedge clk);
        check_pop(32'(a_lerr));
        expect_push("ld12_cnt", 32'h0012);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0012);
        check_pop(32'(a_cnt));
        expect_push("ld12_run", 32'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_run));
        expect_push("run_load_lerr", 32'h1); expect_push("run_load_cnt", 32'h0012);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h1230);
        check_pop(32'(a_lerr)); check_pop(32'(a_cnt));

        // pause keeps the partial second
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        expect_push("dir_up_again", 32'h1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_dir));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        expect_push("pause_run", 32'h0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_pop(32'(a_run));
        repeat (20) @(negedge clk);
        expect_push("pause_cnt", 32'h0); expect_push("pause_tick", 32'h0);
        check_pop(32'(a_cnt)); check_pop(32'(a_tick));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_push("resume_gap", 32'd2);
        wait_tick(n);
        check_pop(32'(n));

        // minute limit on the MAX_MIN=1 instance
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_push("m1_ld_cnt", 32'h0158);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0158);
        check_pop(32'(b_cnt));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_push("m1_gap1", 32'd4);
        wait_tick(n);
        check_pop(32'(n));
        @(negedge clk);
        expect_push("m1_cnt59", 32'h0159); expect_push("m1_exp0", 32'h0);
        check_pop(32'(b_cnt)); check_pop(32'(b_exp));
        expect_push("m1_gap2", 32'd3);
        wait_tick(n);
        check_pop(32'(n));
        @(negedge clk);
        expect_push("m1_exp", 32'h1); expect_push("m1_hold", 32'h0159);
        expect_push("m1_run", 32'h0);
        check_pop(32'(b_exp)); check_pop(32'(b_cnt)); check_pop(32'(b_run));
        expect_push("m1_reload_exp", 32'h0); expect_push("m1_reload_cnt", 32'h0);
        expect_push("m1_reload_lerr", 32'h0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check_pop(32'(b_exp)); check_pop(32'(b_cnt)); check_pop(32'(b_lerr));
        expect_push("m1_over_lerr", 32'h1); expect_push("m1_over_cnt", 32'h0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200);
        check_pop(32'(b_lerr)); check_pop(32'(b_cnt));

        // reset while running
        expect_push("midrst_cnt", 32'h0); expect_push("midrst_run", 32'h0);
        expect_push("midrst_dir", 32'h1); expect_push("midrst_tick", 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check_pop(32'(a_cnt)); check_pop(32'(a_run));
        check_pop(32'(a_dir)); check_pop(32'(a_tick));
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
